branch_predictor: RTL

Fetch-side counterpart to the EX-stage branch comparator. Predicts conditional branches (BEQ/BNE/BLT/BGE) at fetch with a table of 2-bit saturating counters, and remembers each in-flight prediction. When the comparator's taken/not-taken result arrives from EX, the block checks it against the remembered prediction, trains the table, and issues a registered PC redirect plus a front-end flush on a mispredict.

---
 rtl/branch_predictor.sv | 115 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor with an in-flight prediction FIFO and a registered mispredict redirect.
// Define BP_BHT_EN for the 2-bit counter table; otherwise the prediction is static backward-taken/forward-not-taken.
module branch_predictor #(
  parameter int VAR_WIDTH   = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic                 if_stall,
  input  logic                 if_is_branch,
  input  logic [VAR_WIDTH-1:0] if_pc,
  input  logic [VAR_WIDTH-1:0] if_imm,
  output logic                 pred_taken,
  output logic [VAR_WIDTH-1:0] pred_target,
  output logic                 pred_full,
  input  logic                 ex_branch,
  input  logic                 ex_taken,
  input  logic [VAR_WIDTH-1:0] ex_pc,
  input  logic [VAR_WIDTH-1:0] ex_target,
  output logic                 redirect,
  output logic [VAR_WIDTH-1:0] redirect_pc,
  output logic                 flush
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic resolve;
  logic pop;
  logic mispredict;
  logic push;

  function automatic logic [VAR_WIDTH-1:0] fix_pc(input logic                 taken,
                                                  input logic [VAR_WIDTH-1:0] pc,
                                                  input logic [VAR_WIDTH-1:0] tgt);
    return taken ? tgt : pc + VAR_WIDTH'(4);
  endfunction

  assign pred_target = if_pc + if_imm;
  assign pred_full   = (count == CNT_W'(FIFO_DEPTH));

  // A resolution arriving while a redirect is out belongs to a squashed path and is dropped.
  assign resolve    = ex_branch && !redirect;
  assign pop        = resolve && (count != '0);
  assign mispredict = pop && (fifo_mem[head] != ex_taken);
  assign push       = if_valid && if_is_branch && !if_stall && !mispredict &&
                      (!pred_full || pop);

`ifdef BP_BHT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0] bht [BHT_ENTRIES];

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    if (up)
      return (ctr == 2'd3) ? ctr : ctr + 2'd1;
    else
      return (ctr == 2'd0) ? ctr : ctr - 2'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolve) begin
      bht[ex_pc[IDX_W+1:2]] <= sat_update(bht[ex_pc[IDX_W+1:2]], ex_taken);
    end
  end

  assign pred_taken = if_is_branch && bht[if_pc[IDX_W+1:2]][1];
`else
  assign pred_taken = if_is_branch && if_imm[VAR_WIDTH-1];
`endif

  // Stage p0 -> p1: FIFO bookkeeping; a mispredict squashes every younger entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mispredict) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= pred_taken;
  end

  // Stage p0 -> p1: registered redirect and flush pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= mispredict;
      flush    <= mispredict;
      if (mispredict) redirect_pc <= fix_pc(ex_taken, ex_pc, ex_target);
    end
  end

endmodule
